// File: rtl/axi_read_slave.sv
// AXI read slave: per-ID request FIFOs, round-robin burst scheduler, one memory read per beat.
// Latency: AR handshake in cycle N -> mem_rd in N+2 -> first RVALID in N+3; later beats 2 cycles after each R handshake.
// Backpressure: ARREADY low while the addressed ID queue is full; R outputs hold while RREADY is low.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AR*                   read address channel (ID, address, length, size, burst type, handshake)
//   R*                    read data channel (ID, data, response, last, handshake)
//   mem_addr/mem_rd       byte address and read strobe to memory
//   mem_rdata             memory data, valid the cycle after mem_rd
module axi_read_slave #(
    parameter int BusWidth = 32,
    parameter int IdBits   = 2,
    parameter int QDepth   = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [IdBits-1:0]   ARID,
    input  logic [BusWidth-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [IdBits-1:0]   RID,
    output logic [BusWidth-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [BusWidth-1:0] mem_addr,
    output logic                mem_rd,
    input  logic [BusWidth-1:0] mem_rdata
);

    localparam int NQ      = 2 ** IdBits;
    localparam int PtrW    = $clog2(QDepth);
    localparam int MaxSize = $clog2(BusWidth / 8);
    localparam logic [BusWidth-1:0] OneW = BusWidth'(1);

    typedef struct packed {
        logic [BusWidth-1:0] addr;
        logic [3:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } ar_t;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    ar_t               r_mem [NQ][QDepth];
    logic [PtrW-1:0]   r_wp  [NQ];
    logic [PtrW-1:0]   r_rp  [NQ];
    logic [PtrW:0]     r_cnt [NQ];
    logic [IdBits-1:0] r_rr;            // first queue to examine at the next selection

    state_t            r_state, w_state_nxt;
    logic [IdBits-1:0] r_id;
    logic [BusWidth-1:0] r_addr;
    logic [3:0]        r_len, r_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic              r_cap;           // first DATA cycle: memory data is live on mem_rdata
    logic [BusWidth-1:0] r_rdata;

    logic              w_full, w_push, w_pop, w_found, w_hs, w_last, w_head_err;
    logic [IdBits-1:0] w_win;
    ar_t               w_head;
    logic [BusWidth-1:0] w_step, w_span, w_lower, w_inc, w_next_addr;

    assign w_full  = (r_cnt[ARID] == (PtrW+1)'(QDepth));
    assign ARREADY = !ARESET && !w_full;
    assign w_push  = ARVALID && ARREADY;

    // Round-robin search starting at r_rr; first non-empty queue wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NQ; i++) begin
            if (!w_found && (r_cnt[r_rr + IdBits'(i)] != '0)) begin
                w_found = 1'b1;
                w_win   = r_rr + IdBits'(i);
            end
        end
    end

    assign w_head = r_mem[w_win][r_rp[w_win]];

    // Bursts that cannot be served legally are answered with SLVERR beats and never touch memory.
    always_comb begin
        w_head_err = 1'b0;
        if (w_head.size > 3'(MaxSize))
            w_head_err = 1'b1;
        if (w_head.burst == 2'b11)
            w_head_err = 1'b1;
        if ((w_head.burst == 2'b10) &&
            !((w_head.len == 4'd1) || (w_head.len == 4'd3) ||
              (w_head.len == 4'd7) || (w_head.len == 4'd15)))
            w_head_err = 1'b1;
    end

    // Next beat address.
    assign w_step  = OneW << r_size;
    assign w_span  = w_step * {{(BusWidth-5){1'b0}}, ({1'b0, r_len} + 5'd1)};
    assign w_lower = r_addr & ~(w_span - OneW);
    assign w_inc   = r_addr + w_step;

    always_comb begin
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (w_inc == (w_lower + w_span)) ? w_lower : w_inc;
            default: w_next_addr = w_inc;
        endcase
    end

    assign w_last = (r_beat == r_len);
    assign w_hs   = (r_state == DATA) && RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        RVALID      = 1'b0;
        RID         = '0;
        RDATA       = '0;
        RRESP       = 2'b00;
        RLAST       = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                mem_rd      = !r_err;
                mem_addr    = r_addr;
                w_state_nxt = DATA;
            end
            DATA: begin
                RVALID = 1'b1;
                RID    = r_id;
                RRESP  = r_err ? 2'b10 : 2'b00;
                RLAST  = w_last;
                // Live memory data on the first DATA cycle, the captured copy while stalled.
                RDATA  = r_err ? '0 : (r_cap ? mem_rdata : r_rdata);
                if (RREADY)
                    w_state_nxt = w_last ? IDLE : ADDR;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (ARESET) begin
            w_pop    = 1'b0;
            RVALID   = 1'b0;
            RID      = '0;
            RDATA    = '0;
            RRESP    = 2'b00;
            RLAST    = 1'b0;
            mem_rd   = 1'b0;
            mem_addr = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push)
            r_mem[ARID][r_wp[ARID]] <= '{addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NQ; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_rr    <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_cap   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_push)
                r_wp[ARID] <= r_wp[ARID] + PtrW'(1);
            for (int i = 0; i < NQ; i++) begin
                case ({w_push && (ARID == IdBits'(i)), w_pop && (w_win == IdBits'(i))})
                    2'b10:   r_cnt[i] <= r_cnt[i] + (PtrW+1)'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - (PtrW+1)'(1);
                    default: ;
                endcase
            end
            if (w_pop) begin
                r_rp[w_win] <= r_rp[w_win] + PtrW'(1);
                r_rr        <= w_win + IdBits'(1);
                r_id        <= w_win;
                r_addr      <= w_head.addr;
                r_len       <= w_head.len;
                r_size      <= w_head.size;
                r_burst     <= w_head.burst;
                r_err       <= w_head_err;
                r_beat      <= '0;
            end
            r_cap <= (r_state == ADDR);
            if ((r_state == DATA) && r_cap)
                r_rdata <= mem_rdata;
            if (w_hs && !w_last) begin
                r_beat <= r_beat + 4'd1;
                r_addr <= w_next_addr;
            end
        end
    end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 Parameter BusWidth, default 32, data and address width in bits (32 or 64).
REQ-002 Parameter IdBits, default 2, ID width; number of per-ID queues is 2**IdBits.
REQ-003 Parameter QDepth, default 4, entries per per-ID address queue (power of two, >=2).
REQ-004 ACLK  in  1  clock; all logic on rising edge.
REQ-005 ARESET  in  1  reset, synchronous, active-high.
REQ-006 ARID  in  IdBits  AR transaction ID.
REQ-007 ARADDR  in  BusWidth  burst start byte address.
REQ-008 ARLEN  in  4  beats minus one (1-16 beats).
REQ-009 ARSIZE  in  3  bytes per beat = 2**ARSIZE.
REQ-010 ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 ARVALID / ARREADY  in / out  1 each  AR handshake.
REQ-012 RID  out  IdBits; RDATA  out  BusWidth; RRESP  out  2; RLAST  out  1.
REQ-013 RVALID / RREADY  out / in  1 each  R handshake.
REQ-014 mem_addr  out  BusWidth  byte address to memory; mem_rd  out  1  read strobe.
REQ-015 mem_rdata  in  BusWidth  read data, valid exactly one cycle after mem_rd high.

Function
REQ-016 ARREADY SHALL be 1 when queue[ARID] is not full, else 0; AR accepted on ARVALID&&ARREADY into queue[ARID].
REQ-017 Each queue SHALL be FIFO; full/empty per queue; simultaneous push and pop of one queue SHALL both occur.
REQ-018 R FSM states IDLE, ADDR, DATA; reset state IDLE.
REQ-019 IDLE: round-robin over non-empty queues starting at (last served + 1) mod 2**IdBits; pop winner, load ID/addr/len/size/burst, beat count 0, go ADDR; all empty -> stay IDLE.
REQ-020 ADDR: one cycle, mem_rd=1, mem_addr=current address (mem_rd=0 for error bursts), go DATA.
REQ-021 DATA: RVALID=1, RDATA=mem_rdata captured on ADDR->DATA edge, RID=burst ID, RLAST=(beat==len); RVALID, RDATA, RID, RRESP, RLAST SHALL hold stable until RREADY.
REQ-022 On R handshake: RLAST -> IDLE; else beat+1, address update, -> ADDR; RVALID=0 in IDLE/ADDR.
REQ-023 Latency: AR handshake in cycle N on empty block -> mem_rd in N+2, first RVALID in N+3; each subsequent beat RVALID 2 cycles after prior handshake.
REQ-024 FIXED: address unchanged every beat.
REQ-025 INCR: next = addr + 2**size, modulo 2**BusWidth; no 4KB-boundary checking.
REQ-026 WRAP: span = 2**size*(len+1); lower = addr & ~(span-1); next = addr+2**size; if next == lower+span then next = lower.
REQ-027 Error burst: ARSIZE > log2(BusWidth/8), ARBURST=11, or WRAP with len+1 not in {2,4,8,16} -> all len+1 beats RRESP=10 (SLVERR), RDATA=0, no mem_rd.
REQ-028 Legal bursts SHALL return RRESP=00; RDATA SHALL pass mem_rdata unshifted (master selects lanes).
REQ-029 Bursts SHALL not interleave; one burst completes fully before next selection.

Reset
REQ-030 While ARESET=1: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, mem_rd=0, mem_addr=0, all queues empty, round-robin pointer 0, FSM IDLE.
REQ-031 Reset asserted mid-burst SHALL abandon burst and discard queued requests; no RLAST issued.
REQ-032 ARREADY SHALL rise the first cycle after ARESET deasserts.

Verification
REQ-033 INCR: ARID=1, ARADDR=0x100, ARLEN=3, ARSIZE=2, RREADY=1 -> mem_addr 0x100,0x104,0x108,0x10C; 4 beats RID=1, RRESP=00, RLAST on 4th only.
REQ-034 WRAP: ARADDR=0x38, ARLEN=3, ARSIZE=2 -> mem_addr 0x38,0x3C,0x30,0x34.
REQ-035 Round-robin: IDs 0,1,2 each 1-beat burst queued before R starts -> R order 0,1,2; then new ID 0 and 2 pending with last=2 -> 0 before 2.
REQ-036 Backpressure/full: RREADY=0 10 cycles -> R outputs stable; push QDepth+1 requests on ID 3 -> ARREADY=0 on last until one popped; other IDs still accepted.
REQ-037 Error: ARBURST=11, ARLEN=1 -> 2 beats RRESP=10, RDATA=0, mem_rd never high.
REQ-038 Reset mid-burst after beat 2 of 4 -> next cycle all outputs per REQ-030, no further beats.
